// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the control sequencer, function unit and datapath.
//   - opcode encodings OP_NOP..OP_HLT (instr[15:12])
//   - function-select (FS) codes driven into the function unit
//   - bit positions of the fields inside the 16-bit control word
//   - sequencer state encoding
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_INC = 4'h8;
  localparam logic [3:0] OP_LDI = 4'h9;
  localparam logic [3:0] OP_LD  = 4'hA;
  localparam logic [3:0] OP_ST  = 4'hB;
  localparam logic [3:0] OP_BRZ = 4'hC;
  localparam logic [3:0] OP_BRN = 4'hD;
  localparam logic [3:0] OP_JMP = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [3:0] FS_TA  = 4'b0000;
  localparam logic [3:0] FS_INC = 4'b0001;
  localparam logic [3:0] FS_ADD = 4'b0010;
  localparam logic [3:0] FS_SUB = 4'b0101;
  localparam logic [3:0] FS_DEC = 4'b0110;
  localparam logic [3:0] FS_AND = 4'b1000;
  localparam logic [3:0] FS_OR  = 4'b1001;
  localparam logic [3:0] FS_XOR = 4'b1010;
  localparam logic [3:0] FS_NOT = 4'b1011;
  localparam logic [3:0] FS_TB  = 4'b1100;

  // control_word = {DA[15:13], AA[12:10], BA[9:7], MB[6], FS[5:2], MD[1], RW[0]}
  localparam int CW_DA_LSB = 13;
  localparam int CW_AA_LSB = 10;
  localparam int CW_BA_LSB = 7;
  localparam int CW_MB_BIT = 6;
  localparam int CW_FS_LSB = 2;
  localparam int CW_MD_BIT = 1;
  localparam int CW_RW_BIT = 0;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: purely combinational decode of the instruction register.
//   ir            in   16  latched instruction
//   z, d          in   1   zero / negative flags for BRZ / BRN
//   control_word  out  16  datapath control word
//   mem_write     out  1   store strobe (ST)
//   constant_out  out  8   zero-extended imm6 (LDI)
//   branch_taken  out  1   conditional branch condition met
//   pc_sel_jmp    out  1   load PC from the address bus (JMP)
//   is_halt       out  1   HLT opcode
// Outputs are raw decode; the sequencer gates them with its state.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  input  logic        z,
  input  logic        d,
  output logic [15:0] control_word,
  output logic        mem_write,
  output logic [7:0]  constant_out,
  output logic        branch_taken,
  output logic        pc_sel_jmp,
  output logic        is_halt
);

  logic [3:0] op;
  logic [3:0] fs;
  logic       mb, md, rw;

  assign op = ir[15:12];

  always_comb begin
    fs           = FS_TA;
    mb           = 1'b0;
    md           = 1'b0;
    rw           = 1'b0;
    mem_write    = 1'b0;
    constant_out = 8'h00;
    branch_taken = 1'b0;
    pc_sel_jmp   = 1'b0;
    is_halt      = 1'b0;
    case (op)
      OP_MOV: begin fs = FS_TA;  rw = 1'b1; end
      OP_ADD: begin fs = FS_ADD; rw = 1'b1; end
      OP_SUB: begin fs = FS_SUB; rw = 1'b1; end
      OP_AND: begin fs = FS_AND; rw = 1'b1; end
      OP_OR:  begin fs = FS_OR;  rw = 1'b1; end
      OP_XOR: begin fs = FS_XOR; rw = 1'b1; end
      OP_NOT: begin fs = FS_NOT; rw = 1'b1; end
      OP_INC: begin fs = FS_INC; rw = 1'b1; end
      OP_LDI: begin
        mb = 1'b1; fs = FS_TB; rw = 1'b1;
        constant_out = {2'b00, ir[5:0]};
      end
      OP_LD:  begin md = 1'b1; rw = 1'b1; end
      OP_ST:  mem_write = 1'b1;
      OP_BRZ: branch_taken = z;
      OP_BRN: branch_taken = d;
      OP_JMP: pc_sel_jmp = 1'b1;
      OP_HLT: is_halt = 1'b1;
      default: ;
    endcase

    control_word                          = 16'h0000;
    control_word[CW_DA_LSB +: 3]          = ir[11:9];
    control_word[CW_AA_LSB +: 3]          = ir[8:6];
    control_word[CW_BA_LSB +: 3]          = ir[5:3];
    control_word[CW_MB_BIT]               = mb;
    control_word[CW_FS_LSB +: 4]          = fs;
    control_word[CW_MD_BIT]               = md;
    control_word[CW_RW_BIT]               = rw;
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: two-state (fetch/execute) hardwired control unit.
//   clk, reset     clock; synchronous active-high reset
//   step           (only with CONTROL_SEQUENCER_STEP_EN) single-step enable for FETCH
//   instr_in       instruction at pc_out
//   address_in     datapath bus A, JMP target
//   V, C, D, Z     datapath flags (D/Z steer BRN/BRZ)
//   pc_out         current PC
//   control_word   datapath control word, zero outside EXEC
//   constant_out   LDI immediate, zero otherwise
//   mem_write      data-memory write strobe
//   halted         high in HALT
// Optional macro CONTROL_SEQUENCER_STEP_EN: FETCH only advances on step=1.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
  input  logic            clk,
  input  logic            reset,
`ifdef CONTROL_SEQUENCER_STEP_EN
  input  logic            step,
`endif
  input  logic [15:0]     instr_in,
  input  logic [7:0]      address_in,
  input  logic            V,
  input  logic            C,
  input  logic            D,
  input  logic            Z,
  output logic [PC_W-1:0] pc_out,
  output logic [15:0]     control_word,
  output logic [7:0]      constant_out,
  output logic            mem_write,
  output logic            halted
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;

  logic [15:0]     dec_cw;
  logic [7:0]      dec_const;
  logic            dec_mw, dec_br, dec_jmp, dec_halt;
  logic [PC_W-1:0] br_off;
  logic            fetch_en;
  logic            unused_flags;

  // V and C are part of the flag interface but no opcode tests them.
  assign unused_flags = V ^ C;

`ifdef CONTROL_SEQUENCER_STEP_EN
  assign fetch_en = step;
`else
  assign fetch_en = 1'b1;
`endif

  instr_decoder u_dec (
    .ir           (ir_q),
    .z            (Z),
    .d            (D),
    .control_word (dec_cw),
    .mem_write    (dec_mw),
    .constant_out (dec_const),
    .branch_taken (dec_br),
    .pc_sel_jmp   (dec_jmp),
    .is_halt      (dec_halt)
  );

  assign br_off = {{(PC_W-6){ir_q[5]}}, ir_q[5:0]};
  assign pc_out = pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    control_word = 16'h0000;
    constant_out = 8'h00;
    mem_write    = 1'b0;
    halted       = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (fetch_en) begin
          ir_d    = instr_in;
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        control_word = dec_cw;
        constant_out = dec_const;
        mem_write    = dec_mw;
        // pc_q already points past this instruction, so offset 0 falls through.
        if (dec_jmp)     pc_d = PC_W'(address_in);
        else if (dec_br) pc_d = pc_q + br_off;
        state_d = dec_halt ? ST_HALT : ST_FETCH;
      end
      ST_HALT: halted = 1'b1;
      default: state_d = ST_FETCH;
    endcase
    // Reset kills any in-flight EXEC so no register or memory write escapes.
    if (reset) begin
      control_word = 16'h0000;
      constant_out = 8'h00;
      mem_write    = 1'b0;
      halted       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        step;
  logic [15:0] instr_in;
  logic [7:0]  address_in;
  logic        V, C, D, Z;
  logic [7:0]  pc_out;
  logic [15:0] control_word;
  logic [7:0]  constant_out;
  logic        mem_write;
  logic        halted;

  logic [15:0] imem [256];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  assign instr_in = imem[pc_out];

  control_sequencer dut (
    .clk          (clk),
    .reset        (reset),
`ifdef CONTROL_SEQUENCER_STEP_EN
    .step         (step),
`endif
    .instr_in     (instr_in),
    .address_in   (address_in),
    .V            (V),
    .C            (C),
    .D            (D),
    .Z            (Z),
    .pc_out       (pc_out),
    .control_word (control_word),
    .constant_out (constant_out),
    .mem_write    (mem_write),
    .halted       (halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    imem[8'h02] = 16'h9605; // LDI R3,#5
    imem[8'h03] = 16'h2298; // ADD R1,R2,R3
    imem[8'h04] = 16'hB050; // ST [R1]<-R2
    imem[8'h05] = 16'hE000; // JMP
    imem[8'h10] = 16'hC03E; // BRZ -2
    imem[8'h0F] = 16'hC03E; // BRZ -2
    imem[8'h11] = 16'hE000; // JMP
    imem[8'hFF] = 16'hC001; // BRZ +1
    imem[8'h01] = 16'hD001; // BRN +1
    reset = 1'b1; step = 1'b1; address_in = 8'h00;
    V = 1'b0; C = 1'b0; D = 1'b0; Z = 1'b0;

    tick(); tick();
    check("rst_pc", 16'(pc_out), 16'h0000);
    check("rst_cw", control_word, 16'h0000);
    check("rst_halt", 16'(halted), 16'h0000);
    check("rst_mw", 16'(mem_write), 16'h0000);
    reset = 1'b0;
    #1;
    check("rel_pc", 16'(pc_out), 16'h0000);
    repeat (4) tick();
    check("nop_pc", 16'(pc_out), 16'h0002);
    check("fetch_cw", control_word, 16'h0000);

    tick(); // EXEC LDI
    check("ldi_cw", control_word, 16'h6071);
    check("ldi_const", 16'(constant_out), 16'h0005);
    check("ldi_pc", 16'(pc_out), 16'h0003);
    tick(); // FETCH
    check("ldi_const_off", 16'(constant_out), 16'h0000);
    check("fetch_cw2", control_word, 16'h0000);
    tick(); // EXEC ADD
    check("add_cw", control_word, 16'h2989);
    tick(); tick(); // EXEC ST
    check("st_mw", 16'(mem_write), 16'h0001);
    check("st_cw", control_word, 16'h0500);
    tick();
    check("st_mw_once", 16'(mem_write), 16'h0000);

    address_in = 8'h10;
    tick(); tick();
    check("jmp_pc", 16'(pc_out), 16'h0010);

    Z = 1'b1;
    tick();
    check("brz_cw", control_word, 16'h0380);
    tick();
    check("brz_taken_pc", 16'(pc_out), 16'h000F);
    Z = 1'b0;
    tick(); tick();
    check("brz_nt_pc_a", 16'(pc_out), 16'h0010);
    tick(); tick();
    check("brz_nt_pc_b", 16'(pc_out), 16'h0011);

    address_in = 8'hFF;
    tick(); tick();
    check("jmp_ff_pc", 16'(pc_out), 16'h00FF);
    Z = 1'b1;
    tick();
    check("fetch_wrap_pc", 16'(pc_out), 16'h0000);
    tick();
    check("br_wrap_pc", 16'(pc_out), 16'h0001);
    Z = 1'b0; D = 1'b1;
    tick(); tick();
    check("brn_taken_pc", 16'(pc_out), 16'h0003);
    D = 1'b0;

    tick(); // EXEC ADD, then reset mid-EXEC
    check("add2_cw", control_word, 16'h2989);
    reset = 1'b1;
    #1;
    check("rst_exec_cw", control_word, 16'h0000);
    check("rst_exec_mw", 16'(mem_write), 16'h0000);
    tick();
    imem[8'h00] = 16'hF000; // HLT
    reset = 1'b0;
    check("rst_exec_pc", 16'(pc_out), 16'h0000);
    tick(); // EXEC HLT
    check("hlt_exec_pc", 16'(pc_out), 16'h0001);
    check("hlt_exec_halted", 16'(halted), 16'h0000);
    tick();
    for (int i = 0; i < 10; i++) begin
      check("halt_flag", 16'(halted), 16'h0001);
      check("halt_cw", control_word, 16'h0000);
      check("halt_pc", 16'(pc_out), 16'h0001);
      tick();
    end
    reset = 1'b1;
    #1;
    check("halt_rst_flag", 16'(halted), 16'h0000);
    tick();
    reset = 1'b0;
    check("halt_rst_pc", 16'(pc_out), 16'h0000);
    imem[8'h00] = 16'h0000;

`ifdef CONTROL_SEQUENCER_STEP_EN
    step = 1'b0;
    repeat (5) tick();
    check("step_hold_pc", 16'(pc_out), 16'h0000);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("step_adv_pc", 16'(pc_out), 16'h0001);
    repeat (4) tick();
    check("step_once_pc", 16'(pc_out), 16'h0001);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired two-state (fetch/execute) control unit for the 8-register, 8-bit datapath.
- Fetches 16-bit instructions and keeps the PC.
- Decodes each instruction into the 16-bit datapath control word, plus memory-write, constant and halt signals.
- Consumes the datapath status flags (V, C, D, Z) and address bus for branches and jumps.

Parameters:
- PC_W, 8, program-counter and instruction-address width.
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_in  in  16  instruction word at pc_out (combinational instruction memory).
- address_in  in  8  datapath Bus_A (Address_out); JMP target.
- V  in  1  datapath overflow flag.
- C  in  1  datapath carry flag.
- D  in  1  datapath negative flag (result MSB).
- Z  in  1  datapath zero flag.
- pc_out  out  PC_W  current PC.
- control_word  out  16  {DA[15:13], AA[12:10], BA[9:7], MB[6], FS[5:2], MD[1], RW[0]}.
- constant_out  out  8  zero-extended imm6 for MB=1.
- mem_write  out  1  data-memory write strobe.
- halted  out  1  high in HALT state.

Behaviour:
- Instruction fields: op[15:12], DR[11:9], SA[8:6], SB[5:3], imm6[5:0] (overlaps SB).
- States: FETCH, EXEC, HALT.
- Reset:
  - Next edge sets state=FETCH, PC=RESET_PC, IR=0.
  - While reset is high, control_word=0, mem_write=0, constant_out=0, halted=0, whatever the state.
  - Reset mid-EXEC abandons the instruction; no register or memory write happens.
- FETCH:
  - IR<=instr_in; PC<=PC+1, wrapping 8'hFF->8'h00; next state EXEC.
  - control_word=0 (RW=0), mem_write=0.
- EXEC:
  - control_word and mem_write are decoded combinationally from IR.
  - Next state is FETCH, or HALT for HLT.
  - Each instruction takes exactly 2 cycles.
- Default fields: DA=DR, AA=SA, BA=SB, MB=0, MD=0, RW=0. FS values below come from the shared package.
- Opcodes:
  - 0 NOP: no writes.
  - 1 MOV: FS=TA, RW=1.
  - 2 ADD: FS=ADD, RW=1.
  - 3 SUB: FS=SUB, RW=1.
  - 4 AND: FS=AND, RW=1.
  - 5 OR: FS=OR, RW=1.
  - 6 XOR: FS=XOR, RW=1.
  - 7 NOT: FS=NOT, RW=1.
  - 8 INC: FS=INC, RW=1.
  - 9 LDI: MB=1, FS=TB, RW=1, constant_out={2'b0,imm6}.
  - A LD: MD=1, RW=1 (R[DR]<=M[R[SA]]).
  - B ST: mem_write=1 for the single EXEC cycle, RW=0.
  - C BRZ: FS=TA; if Z then PC<=PC+sext(imm6), modulo 256.
  - D BRN: FS=TA; if D then PC<=PC+sext(imm6), modulo 256.
  - E JMP: FS=TA; PC<=address_in.
  - F HLT: enter HALT.
- The PC used in branch targets is the already-incremented value, so an offset of 0 falls through.
- Flags are sampled in the same EXEC cycle. The combinational path datapath->flags->PC is accepted.
- HALT:
  - control_word=0, mem_write=0, halted=1.
  - PC frozen; remains here until reset.
- constant_out=0 except during LDI EXEC.

Optional Feature:
- Macro: CONTROL_SEQUENCER_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - FSM leaves FETCH only on a cycle with step=1. Otherwise it holds FETCH with PC and IR unchanged.
  - EXEC is unaffected.
- Undefined: no step port; free-running as above.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams OP_NOP..OP_HLT;
  - FS codes: TA=0000, INC=0001, ADD=0010, SUB=0101, DEC=0110, AND=1000, OR=1001, XOR=1010, NOT=1011, TB=1100;
  - control-word bit-position constants;
  - state encoding.
- Function_unit and the datapath import the same FS constants.
- One sub-module, instr_decoder: combinational, IR plus flags -> control_word, mem_write, constant_out, branch_taken, next-PC select.
- PC, IR and FSM stay in control_sequencer.

Test Plan:
- Reset held 2 cycles, then released with instr_in=16'h0000 -> pc_out=0x00, control_word=0, halted=0; after 4 cycles pc_out=0x02.
- LDI R3,#5 (16'h9605) in EXEC -> control_word={3'd3,3'd0,3'd0,1,TB,0,1}, constant_out=8'h05.
- ADD R1,R2,R3 (16'h2298) in EXEC -> control_word={3'd1,3'd2,3'd3,0,ADD,0,1}; ST R2->[R1] -> mem_write=1 for exactly one cycle with RW=0.
- BRZ at PC=0x10, imm6=6'h3E (-2):
  - Z=1 -> next pc_out=0x0F;
  - Z=0 -> pc_out=0x11;
  - branch at PC=0xFF with imm6=1 -> wraps to 0x01.
- JMP with address_in=0x80 -> pc_out=0x80 after EXEC. HLT -> halted=1 and control_word=0 for 10 cycles; reset then returns pc_out=0x00.
- Reset asserted during EXEC of ADD (RW would be 1) -> control_word=0 that cycle, no register write, next state FETCH.
- With the step macro: step=0 for 5 cycles -> pc_out unchanged; a 1-cycle step pulse advances exactly one instruction.
